// File: rtl/spi_cmd_exec_pkg.sv
// Shared command/status encodings for the SPI command executor.
// No logic, no latency.
// No flow control.
package spi_cmd_exec_pkg;

    localparam logic [1:0] MODE_STA  = 2'd0;
    localparam logic [1:0] MODE_DAT  = 2'd1;
    localparam logic [1:0] MODE_ADR  = 2'd2;
    localparam logic [1:0] MODE_FULL = 2'd3;

    localparam int CMD_CONT  = 2;
    localparam int CMD_WRITE = 3;

    localparam int STA_BUSY    = 0;
    localparam int STA_DIRTY   = 1;
    localparam int STA_WR_DONE = 2;
    localparam int STA_ERR     = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_WR_REQ,
        S_WAIT_ACK,
        S_ERR
    } state_t;

    // Transaction length in bytes for a given mode.
    function automatic logic [2:0] cmd_len(input logic [1:0] mode);
        return 3'(mode) + 3'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_exec_if.sv
// Sniffer register bus between the command executor and the register file.
// No logic, no latency.
// Request is held by the master until a one-cycle ack from the slave.
interface spi_cmd_exec_if;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_req;
    logic        reg_we;
    logic [7:0]  reg_rdata;
    logic        reg_ack;

    modport master (
        output reg_addr, reg_wdata, reg_req, reg_we,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_req, reg_we,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/spi_cmd_exec_bus_timeout.sv
// Register-bus watchdog: load arms it, clear disarms it.
// expired pulses one cycle, TIMEOUT+1 cycles after load when never cleared.
// No backpressure.
module spi_cmd_exec_bus_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expired
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;
    logic          running;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                cnt     <= CW'(TIMEOUT - 1);
                running <= 1'b1;
            end else if (clear) begin
                running <= 1'b0;
            end else if (running) begin
                if (cnt == '0) begin
                    expired <= 1'b1;
                    running <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/spi_cmd_exec.sv
// SPI command executor: turns per-byte CMD/ADDR/DATA events into register-bus accesses (SPI_CMD_AUTOINC_EN: CONT post-increments ptr).
// Bus request issued the cycle after the qualifying eob; read data lands in data_o the cycle after ack.
// Holds reg_req until ack or TIMEOUT; eob arriving while an access is outstanding is dropped and flagged.
module spi_cmd_exec
    import spi_cmd_exec_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int STA_EXT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           cmd_i,
    input  logic [15:0]          addr_i,
    input  logic [7:0]           data_i,
    input  logic                 eob_i,
    input  logic                 busy_i,
    input  logic                 err_i,
    input  logic [STA_EXT_W-1:0] sta_ext_i,
    output logic [7:0]           sta_o,
    output logic [7:0]           data_o,
    output logic                 err_o,
    spi_cmd_exec_if.master       bus
);
`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_t      state;
    logic [2:0]  byte_cnt;
    logic [15:0] ptr;
    logic        ptr_dirty, wr_done, err_sticky;
    logic        abort, discard, acc_inc;
    logic        tmo_expired;

    logic [1:0]  mode;
    logic        cmd_we, data_mode;
    logic [2:0]  byte_n;
    logic        exec_ok, acc_ok, issue_rd, issue_wr, acc_done, rd_keep;
    logic        unused_cmd;

    assign mode      = cmd_i[1:0];
    assign cmd_we    = cmd_i[CMD_WRITE];
    assign data_mode = (mode == MODE_DAT) || (mode == MODE_FULL);
    assign byte_n    = byte_cnt + 3'd1;
    assign exec_ok   = eob_i && busy_i && (state == S_IDLE);
    assign acc_ok    = exec_ok && !err_i && !abort;
    // Reads prefetch one byte early so data_o is ready before the MISO byte; writes wait for the data byte.
    assign issue_rd  = acc_ok && data_mode && !cmd_we && (byte_n == cmd_len(mode) - 3'd1);
    assign issue_wr  = acc_ok && data_mode &&  cmd_we && (byte_n == cmd_len(mode));
    assign acc_done  = bus.reg_ack &&
                       (state == S_RD_REQ || state == S_WR_REQ || state == S_WAIT_ACK);
    assign rd_keep   = !discard && busy_i;
    assign unused_cmd = ^cmd_i[7:4];

    assign sta_o[7:4]        = 4'(sta_ext_i);
    assign sta_o[STA_ERR]     = err_sticky;
    assign sta_o[STA_WR_DONE] = wr_done;
    assign sta_o[STA_DIRTY]   = ptr_dirty;
    assign sta_o[STA_BUSY]    = (state != S_IDLE);

    spi_cmd_exec_bus_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .load    (issue_rd | issue_wr),
        .clear   (bus.reg_ack),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            byte_cnt      <= '0;
            ptr           <= '0;
            ptr_dirty     <= 1'b0;
            wr_done       <= 1'b0;
            err_sticky    <= 1'b0;
            abort         <= 1'b0;
            discard       <= 1'b0;
            acc_inc       <= 1'b0;
            data_o        <= '0;
            err_o         <= 1'b0;
            bus.reg_req   <= 1'b0;
            bus.reg_we    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
        end else begin
            err_o <= 1'b0;
            if (!busy_i) begin
                byte_cnt <= '0;
                abort    <= 1'b0;
            end else begin
                if (eob_i && byte_cnt != 3'd7) byte_cnt <= byte_n;
                if (err_i) abort <= 1'b1;
            end
            if (!busy_i && state != S_IDLE) discard <= 1'b1;

            if (exec_ok && byte_n == 3'd1) begin
                wr_done <= 1'b0;
                if (mode == MODE_STA) begin
                    if (cmd_we) err_sticky <= 1'b0;
                    else        ptr_dirty  <= 1'b0;
                end
            end
            if (exec_ok && byte_n == 3'd3 && (mode == MODE_ADR || mode == MODE_FULL)) begin
                ptr       <= addr_i;
                ptr_dirty <= 1'b1;
            end
            if (err_i || (eob_i && busy_i && state != S_IDLE)) err_sticky <= 1'b1;

            if (acc_done) begin
                state       <= S_IDLE;
                bus.reg_req <= 1'b0;
                bus.reg_we  <= 1'b0;
                if (bus.reg_we) wr_done <= 1'b1;
                else if (rd_keep) data_o <= bus.reg_rdata;
                if (AUTOINC && acc_inc && (bus.reg_we || rd_keep)) begin
                    ptr       <= bus.reg_addr + 16'd1;
                    ptr_dirty <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: if (issue_rd || issue_wr) begin
                        state         <= issue_wr ? S_WR_REQ : S_RD_REQ;
                        bus.reg_req   <= 1'b1;
                        bus.reg_we    <= issue_wr;
                        bus.reg_addr  <= (mode == MODE_FULL) ? addr_i : ptr;
                        bus.reg_wdata <= data_i;
                        acc_inc       <= cmd_i[CMD_CONT];
                        discard       <= 1'b0;
                    end
                    S_RD_REQ, S_WR_REQ: state <= S_WAIT_ACK;
                    S_WAIT_ACK: if (tmo_expired) begin
                        state       <= S_ERR;
                        bus.reg_req <= 1'b0;
                        bus.reg_we  <= 1'b0;
                        err_o       <= 1'b1;
                        err_sticky  <= 1'b1;
                        data_o      <= 8'hFF;
                    end
                    S_ERR:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_cmd_exec.sv
// Directed and randomized transactions against a transaction-level model of the executor.
// Register-bus responder with programmable ack delay (0 = never ack).
module tb_spi_cmd_exec;
    localparam int TIMEOUT = 16;
    localparam int GAP     = TIMEOUT + 10;
`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_i, data_i, sta_o, data_o;
    logic [15:0] addr_i;
    logic        eob_i, busy_i, err_i, err_o;
    logic [3:0]  sta_ext_i;

    spi_cmd_exec_if bus ();

    spi_cmd_exec #(.TIMEOUT(TIMEOUT), .STA_EXT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_i     (cmd_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .eob_i     (eob_i),
        .busy_i    (busy_i),
        .err_i     (err_i),
        .sta_ext_i (sta_ext_i),
        .sta_o     (sta_o),
        .data_o    (data_o),
        .err_o     (err_o),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [15:0] m_ptr    = '0;
    logic        m_dirty  = 1'b0;
    logic        m_sticky = 1'b0;
    logic        m_wrdone = 1'b0;
    logic [7:0]  m_data   = '0;
    int          m_errp   = 0;

    // Bus observation: {we, addr, wdata}
    logic [24:0] acc_q[$];
    logic [24:0] exp_q[$];
    logic [24:0] cap        = '0;
    int          req_age    = 0;
    int          last_age   = 0;
    int          err_pulses = 0;
    int          stab_bad   = 0;
    int          rsp_dly    = 1;
    logic [7:0]  rsp_data   = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = '0;
        forever begin
            @(negedge clk);
            bus.reg_ack = 1'b0;
            if (err_o) err_pulses++;
            if (bus.reg_req) begin
                if (req_age == 0) begin
                    cap = {bus.reg_we, bus.reg_addr, bus.reg_we ? bus.reg_wdata : 8'h00};
                    acc_q.push_back(cap);
                end else if (cap != {bus.reg_we, bus.reg_addr, bus.reg_we ? bus.reg_wdata : 8'h00}) begin
                    stab_bad++;
                end
                req_age++;
                if (rsp_dly != 0 && req_age == rsp_dly) begin
                    bus.reg_ack   = 1'b1;
                    bus.reg_rdata = rsp_data;
                end
            end else begin
                if (req_age != 0) last_age = req_age;
                req_age = 0;
            end
        end
    end

    task automatic run_txn(input logic [1:0] mode, input logic we, input logic cont,
                           input logic [15:0] addr, input logic [7:0] data, input int nbytes,
                           input logic [7:0] rdata, input int dly, input logic err_first);
        logic [15:0] a;
        logic        rd_iss, wr_iss;
        int          len;
        len = int'(mode) + 1;
        exp_q.delete();
        acc_q.delete();
        // Expected outcome of the whole transaction
        if (err_first) m_sticky = 1'b1;
        if (nbytes >= 1) begin
            m_wrdone = 1'b0;
            if (mode == 2'd0) begin
                if (we) m_sticky = 1'b0;
                else    m_dirty  = 1'b0;
            end
        end
        a = (mode == 2'd3) ? addr : m_ptr;
        if (mode >= 2'd2 && nbytes >= 3) begin
            m_ptr   = addr;
            m_dirty = 1'b1;
        end
        rd_iss = !err_first && !we && ((mode == 2'd1 && nbytes >= 1) || (mode == 2'd3 && nbytes >= 3));
        wr_iss = !err_first &&  we && (mode == 2'd1 || mode == 2'd3) && nbytes >= len;
        if (rd_iss || wr_iss) begin
            exp_q.push_back({wr_iss, a, wr_iss ? data : 8'h00});
            if (dly == 0) begin
                m_sticky = 1'b1;
                m_data   = 8'hFF;
                m_errp++;
            end else begin
                if (wr_iss) m_wrdone = 1'b1;
                else        m_data   = rdata;
                if (AUTOINC && cont) begin
                    m_ptr   = a + 16'd1;
                    m_dirty = 1'b1;
                end
            end
        end

        rsp_dly  = dly;
        rsp_data = rdata;
        @(posedge clk); #1;
        busy_i = 1'b1;
        cmd_i  = {4'($urandom), we, cont, mode};
        addr_i = addr;
        data_i = data;
        if (err_first) begin
            err_i = 1'b1;
            @(posedge clk); #1;
            err_i = 1'b0;
        end
        for (int b = 1; b <= nbytes; b++) begin
            repeat (GAP) @(posedge clk);
            #1 eob_i = 1'b1;
            @(posedge clk); #1;
            eob_i = 1'b0;
        end
        repeat (GAP) @(posedge clk);
        #1 busy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check_eq("acc_n", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            check_eq("acc", 32'(acc_q[i]), 32'(exp_q[i]));
        check_eq("sta", sta_o, {sta_ext_i, m_sticky, m_wrdone, m_dirty, 1'b0});
        check_eq("data", data_o, m_data);
        check_eq("ptr", dut.ptr, m_ptr);
        check_eq("err_pulses", err_pulses, m_errp);
        check_eq("stable", stab_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] mode;
        logic       we;
        int         nb;
        rst = 1'b0;
        cmd_i = '0; addr_i = '0; data_i = '0;
        eob_i = 1'b0; busy_i = 1'b0; err_i = 1'b0; sta_ext_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sta", sta_o, 8'h00);
        check_eq("rst_data", data_o, 8'h00);
        check_eq("rst_err", err_o, 1'b0);
        check_eq("rst_req", bus.reg_req, 1'b0);
        check_eq("rst_addr", bus.reg_addr, 16'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Status-only read
        sta_ext_i = 4'hA;
        run_txn(2'd0, 1'b0, 1'b0, 16'h0, 8'h00, 1, 8'h00, 1, 1'b0);
        check_eq("t1_sta", sta_o, 8'hA0);

        // Pointer load then read at pointer
        run_txn(2'd2, 1'b0, 1'b0, 16'h1234, 8'h00, 3, 8'h00, 1, 1'b0);
        check_eq("t2_dirty", sta_o[1], 1'b1);
        run_txn(2'd1, 1'b0, 1'b0, 16'h0000, 8'h00, 2, 8'h5A, 3, 1'b0);
        check_eq("t2_data", data_o, 8'h5A);

        // Full write at FFFF with CONT: pointer wrap
        run_txn(2'd3, 1'b1, 1'b1, 16'hFFFF, 8'hC3, 4, 8'h00, 2, 1'b0);
        check_eq("t3_wr_done", sta_o[2], 1'b1);
        check_eq("t3_ptr", dut.ptr, AUTOINC ? 16'h0000 : 16'hFFFF);

        // Read with no ack: timeout, then sticky cleared by status write
        run_txn(2'd1, 1'b0, 1'b0, 16'h0000, 8'h00, 2, 8'h00, 0, 1'b0);
        check_eq("t4_sticky", sta_o[3], 1'b1);
        check_eq("t4_len", (last_age >= TIMEOUT && last_age <= TIMEOUT + 2), 1'b1);
        run_txn(2'd0, 1'b1, 1'b0, 16'h0000, 8'h00, 1, 8'h00, 1, 1'b0);
        check_eq("t4_clear", sta_o[3], 1'b0);

        // Write truncated after byte 3
        run_txn(2'd3, 1'b1, 1'b0, 16'hBEEF, 8'h11, 3, 8'h00, 1, 1'b0);

        // SS deasserts while a read is outstanding: data is dropped
        acc_q.delete();
        rsp_dly  = 4;
        rsp_data = 8'h77;
        m_wrdone = 1'b0;
        @(posedge clk); #1;
        busy_i = 1'b1; cmd_i = 8'h01; eob_i = 1'b1;
        @(posedge clk); #1;
        eob_i = 1'b0; busy_i = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        check_eq("disc_data", data_o, m_data);
        check_eq("disc_n", acc_q.size(), 1);
        if (acc_q.size() == 1) check_eq("disc_addr", 32'(acc_q[0]), {7'd0, 1'b0, m_ptr, 8'h00});

        // Asynchronous reset while waiting for ack
        sta_ext_i = 4'h0;
        rsp_dly   = 0;
        @(posedge clk); #1;
        busy_i = 1'b1; cmd_i = 8'h01; eob_i = 1'b1;
        @(posedge clk); #1;
        eob_i = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_eq("arst_sta", sta_o, 8'h00);
        check_eq("arst_data", data_o, 8'h00);
        check_eq("arst_req", bus.reg_req, 1'b0);
        check_eq("arst_addr", bus.reg_addr, 16'h0);
        busy_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("arst_idle", sta_o[0], 1'b0);
        check_eq("arst_ptr", dut.ptr, 16'h0);
        m_ptr = '0; m_dirty = 1'b0; m_sticky = 1'b0; m_wrdone = 1'b0; m_data = '0;

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            mode      = 2'($urandom);
            we        = 1'($urandom);
            nb        = int'(mode) + 1;
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, int'(mode) + 1);
            sta_ext_i = 4'($urandom);
            run_txn(mode, we, 1'($urandom), 16'($urandom), 8'($urandom), nb, 8'($urandom),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6),
                    mode[0] && ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
